// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared light codes, lane indices and driver state encoding
package traffic_light_pkg;

    localparam logic [3:0] CODE_ALL_RED = 4'd0;
    localparam logic [3:0] CODE_GRN_NS1 = 4'd1;
    localparam logic [3:0] CODE_YEL_NS1 = 4'd2;
    localparam logic [3:0] CODE_GRN_NS2 = 4'd3;
    localparam logic [3:0] CODE_YEL_NS2 = 4'd4;
    localparam logic [3:0] CODE_GRN_EW1 = 4'd5;
    localparam logic [3:0] CODE_YEL_EW1 = 4'd6;
    localparam logic [3:0] CODE_GRN_EW2 = 4'd7;
    localparam logic [3:0] CODE_YEL_EW2 = 4'd8;

    localparam logic [1:0] LANE_NS1 = 2'd0;
    localparam logic [1:0] LANE_NS2 = 2'd1;
    localparam logic [1:0] LANE_EW1 = 2'd2;
    localparam logic [1:0] LANE_EW2 = 2'd3;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FAULT  = 2'd3
    } drv_state_e;

    function automatic logic code_is_green(input logic [3:0] c);
        return c inside {CODE_GRN_NS1, CODE_GRN_NS2, CODE_GRN_EW1, CODE_GRN_EW2};
    endfunction

    function automatic logic code_is_yellow(input logic [3:0] c);
        return c inside {CODE_YEL_NS1, CODE_YEL_NS2, CODE_YEL_EW1, CODE_YEL_EW2};
    endfunction

    // Codes 1..8 pair up per lane: (code-1)>>1 gives the lane index.
    function automatic logic [1:0] code_lane(input logic [3:0] c);
        logic [3:0] m;
        m = c - 4'd1;
        return m[2:1];
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] l);
        case (l)
            LANE_NS1: return 4'b0001;
            LANE_NS2: return 4'b0010;
            LANE_EW1: return 4'b0100;
            LANE_EW2: return 4'b1000;
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lamp_flasher.sv
// rtl/lamp_flasher.sv - square-wave generator for the fault red flash
module lamp_flasher #(
    parameter int FLASH_HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic on
);

    localparam int FW = $clog2(2 * FLASH_HALF);
    localparam logic [FW-1:0] WRAP = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] HALF = FW'(FLASH_HALF);

    logic [FW-1:0] cnt;

    // Held at zero while disabled so every fault entry starts with the lamps lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == WRAP) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign on = enable && (cnt < HALF);

endmodule

// File: rtl/light_head_driver.sv
// rtl/light_head_driver.sv - lamp driver enforcing yellow and all-red clearance between greens
module light_head_driver
    import traffic_light_pkg::*;
#(
    parameter int CLEAR_CYCLES = 2,
    parameter int FAULT_LIMIT  = 3,
    parameter int FLASH_HALF   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] light_code,
    input  logic       fault_clr,
    output logic [3:0] lamp_red,
    output logic [3:0] lamp_yel,
    output logic [3:0] lamp_grn,
    output logic       clearing,
    output logic       fault
);

    localparam int CW = $clog2(CLEAR_CYCLES + 2);
    localparam int IW = $clog2(FAULT_LIMIT + 1);
    localparam logic [CW-1:0] CLR_MAX  = CW'(CLEAR_CYCLES);
    localparam logic [IW-1:0] ILL_LAST = IW'(FAULT_LIMIT - 1);

    drv_state_e    state, state_d;
    logic [1:0]    lane, lane_d;
    logic [3:0]    code_q;
    logic [CW-1:0] clr_cnt, clr_d;
    logic [IW-1:0] ill_cnt, ill_d;
    logic          is_grn, is_yel, legal, flash_on;
    logic [1:0]    code_ln;
    logic [3:0]    mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RED;
            lane    <= LANE_NS1;
            code_q  <= CODE_ALL_RED;
            clr_cnt <= '0;
            ill_cnt <= '0;
        end else begin
            state   <= state_d;
            lane    <= lane_d;
            code_q  <= light_code;
            clr_cnt <= clr_d;
            ill_cnt <= ill_d;
        end
    end

    assign is_grn  = code_is_green(code_q);
    assign is_yel  = code_is_yellow(code_q);
    assign legal   = (code_q <= CODE_YEL_EW2);
    assign code_ln = code_lane(code_q);

    always_comb begin
        state_d = state;
        lane_d  = lane;
        clr_d   = clr_cnt;
        ill_d   = ill_cnt;
        if (state == ST_FAULT) begin
            if (fault_clr && code_q == CODE_ALL_RED) begin
                state_d = ST_RED;
                clr_d   = '0;
                ill_d   = '0;
            end
        end else if (!legal) begin
            // Illegal codes freeze everything except the illegal-run counter.
            if (ill_cnt == ILL_LAST) begin
                state_d = ST_FAULT;
                ill_d   = '0;
            end else begin
                ill_d = ill_cnt + 1'b1;
            end
        end else begin
            ill_d = '0;
            case (state)
                ST_RED: begin
                    if (clr_cnt != CLR_MAX) clr_d = clr_cnt + 1'b1;
                    if (is_yel) begin
                        state_d = ST_FAULT;
                    end else if (is_grn && clr_cnt >= CLR_MAX) begin
                        state_d = ST_GREEN;
                        lane_d  = code_ln;
                    end
                end
                ST_GREEN: begin
                    if (is_yel && code_ln == lane) state_d = ST_YELLOW;
                    else if (!(is_grn && code_ln == lane)) state_d = ST_FAULT;
                end
                ST_YELLOW: begin
                    if (is_yel) begin
                        if (code_ln != lane) state_d = ST_FAULT;
                    end else begin
                        state_d = ST_RED;
                        clr_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    lamp_flasher #(.FLASH_HALF(FLASH_HALF)) u_flasher (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == ST_FAULT),
        .on     (flash_on)
    );

    assign mask = lane_mask(lane);

    // Lamps depend only on registered state, so reset forces all-red at once.
    always_comb begin
        lamp_red = 4'b1111;
        lamp_yel = 4'b0000;
        lamp_grn = 4'b0000;
        case (state)
            ST_GREEN: begin
                lamp_grn = mask;
                lamp_red = ~mask;
            end
            ST_YELLOW: begin
                lamp_yel = mask;
                lamp_red = ~mask;
            end
            ST_FAULT: lamp_red = {4{flash_on}};
            default: ;
        endcase
    end

    assign fault    = (state == ST_FAULT);
    assign clearing = (state == ST_RED) && is_grn && (clr_cnt < CLR_MAX);

endmodule

// File: tb/tb_light_head_driver.sv
// tb/tb_light_head_driver.sv - directed self-checking bench for light_head_driver
module tb_light_head_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] light_code;
    logic       fault_clr;
    logic [3:0] lamp_red, lamp_yel, lamp_grn;
    logic       clearing, fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    light_head_driver #(
        .CLEAR_CYCLES (2),
        .FAULT_LIMIT  (3),
        .FLASH_HALF   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .light_code (light_code),
        .fault_clr  (fault_clr),
        .lamp_red   (lamp_red),
        .lamp_yel   (lamp_yel),
        .lamp_grn   (lamp_grn),
        .clearing   (clearing),
        .fault      (fault)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_lamps(input string tag, input logic [3:0] r, input logic [3:0] y,
                               input logic [3:0] g);
        check_val({tag, "_red"}, {4'b0, lamp_red}, {4'b0, r});
        check_val({tag, "_yel"}, {4'b0, lamp_yel}, {4'b0, y});
        check_val({tag, "_grn"}, {4'b0, lamp_grn}, {4'b0, g});
    endtask

    task automatic reset_with(input logic [3:0] code);
        rst_n      = 1'b0;
        light_code = code;
        fault_clr  = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        reset_with(4'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_lamps("rst", 4'b1111, 4'b0000, 4'b0000);
        check_val("rst_fault", {7'b0, fault}, 8'd0);
        check_val("rst_clearing", {7'b0, clearing}, 8'd0);

        // Green request straight out of reset must wait for clearance
        light_code = 4'd1;
        rst_n      = 1'b1;
        tick();
        check_lamps("clr1", 4'b1111, 4'b0000, 4'b0000);
        check_val("clr1_clearing", {7'b0, clearing}, 8'd1);
        tick();
        check_lamps("clr2", 4'b1111, 4'b0000, 4'b0000);
        tick();
        check_lamps("grn_ns1", 4'b1110, 4'b0000, 4'b0001);

        // Green NS1 -> yellow NS1 -> all-red -> green NS2
        ticks(5);
        check_lamps("hold_ns1", 4'b1110, 4'b0000, 4'b0001);
        light_code = 4'd2;
        tick();
        check_lamps("yel_lat", 4'b1110, 4'b0000, 4'b0001);
        tick();
        check_lamps("yel_ns1", 4'b1110, 4'b0001, 4'b0000);
        tick();
        light_code = 4'd3;
        tick();
        check_lamps("yel_hold", 4'b1110, 4'b0001, 4'b0000);
        tick();
        check_lamps("ar1", 4'b1111, 4'b0000, 4'b0000);
        check_val("ar1_clearing", {7'b0, clearing}, 8'd1);
        tick();
        check_lamps("ar2", 4'b1111, 4'b0000, 4'b0000);
        tick();
        check_lamps("ar3", 4'b1111, 4'b0000, 4'b0000);
        tick();
        check_lamps("grn_ns2", 4'b1101, 4'b0000, 4'b0010);
        check_val("seq_fault", {7'b0, fault}, 8'd0);

        // Green NS1 then NS2 without yellow -> fault, red flashes 4 on / 4 off
        reset_with(4'd1);
        ticks(3);
        check_lamps("f_grn_ns1", 4'b1110, 4'b0000, 4'b0001);
        light_code = 4'd3;
        tick();
        check_val("f_pre", {7'b0, fault}, 8'd0);
        tick();
        check_val("f_entry", {7'b0, fault}, 8'd1);
        for (int i = 0; i < 9; i++) begin
            check_lamps($sformatf("flash%0d", i), (i % 8 < 4) ? 4'b1111 : 4'b0000,
                        4'b0000, 4'b0000);
            tick();
        end

        // Leave fault only with fault_clr and code 0
        light_code = 4'd5;
        fault_clr  = 1'b1;
        ticks(2);
        check_val("fclr_code5", {7'b0, fault}, 8'd1);
        light_code = 4'd0;
        tick();
        check_val("fclr_lat", {7'b0, fault}, 8'd1);
        tick();
        check_val("fclr_exit", {7'b0, fault}, 8'd0);
        check_lamps("fclr_red", 4'b1111, 4'b0000, 4'b0000);
        fault_clr  = 1'b0;
        light_code = 4'd5;
        tick();
        check_val("fclr_restart", {7'b0, clearing}, 8'd1);
        tick();
        check_lamps("fclr_ar", 4'b1111, 4'b0000, 4'b0000);
        tick();
        check_lamps("grn_ew1", 4'b1011, 4'b0000, 4'b0100);

        // Two illegal codes are tolerated, three force fault
        light_code = 4'd12;
        ticks(2);
        light_code = 4'd5;
        tick();
        check_lamps("ill2_hold", 4'b1011, 4'b0000, 4'b0100);
        tick();
        check_lamps("ill2_after", 4'b1011, 4'b0000, 4'b0100);
        check_val("ill2_fault", {7'b0, fault}, 8'd0);
        light_code = 4'd12;
        ticks(3);
        light_code = 4'd5;
        check_val("ill3_pre", {7'b0, fault}, 8'd0);
        tick();
        check_val("ill3_fault", {7'b0, fault}, 8'd1);
        check_lamps("ill3_lamps", 4'b1111, 4'b0000, 4'b0000);

        // Asynchronous reset mid-green NS2
        light_code = 4'd0;
        fault_clr  = 1'b1;
        ticks(2);
        fault_clr  = 1'b0;
        light_code = 4'd3;
        ticks(3);
        check_lamps("pre_rst_ns2", 4'b1101, 4'b0000, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check_lamps("async_rst", 4'b1111, 4'b0000, 4'b0000);
        check_val("async_rst_fault", {7'b0, fault}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_clearing", {7'b0, clearing}, 8'd1);
        tick();
        check_lamps("post_rst_ar", 4'b1111, 4'b0000, 4'b0000);
        tick();
        check_lamps("post_rst_grn", 4'b1101, 4'b0000, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_head_driver.md
LIGHT_HEAD_DRIVER -- requirements
Module: light_head_driver

Interface
REQ-001 The block SHALL have the parameter CLEAR_CYCLES, default 2: minimum number of all-red cycles before any green is shown.
REQ-002 The block SHALL have the parameter FAULT_LIMIT, default 3: number of consecutive illegal codes that forces FAULT.
REQ-003 The block SHALL have the parameter FLASH_HALF, default 4: half-period, in cycles, of the fault red flash.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the port light_code, input, 4 bits: encoded light command from the traffic controller FSM.
REQ-007 The block SHALL have the port fault_clr, input, 1 bit: request to leave FAULT.
REQ-008 The block SHALL have the ports lamp_red, lamp_yel and lamp_grn, output, 4 bits each, with lane index 0=NS1, 1=NS2, 2=EW1, 3=EW2.
REQ-009 The block SHALL have the port clearing, output, 1 bit: all-red is being held because clearance is not yet met.
REQ-010 The block SHALL have the port fault, output, 1 bit: FAULT state is active.

Function
REQ-011 The block SHALL decode light_code as follows:
- 0: all red.
- Green: 1=NS1, 3=NS2, 5=EW1, 7=EW2.
- Yellow: 2=NS1, 4=NS2, 6=EW1, 8=EW2.
- 9-15: illegal.
REQ-012 The block SHALL register light_code into code_q; lamps SHALL decode only from the state and lane registers, with 2-cycle latency from light_code to lamps and no combinational path from light_code to any output.
REQ-013 The block SHALL have exactly four states: RED, GREEN(lane), YELLOW(lane), FAULT; lane is a 2-bit register.
REQ-014 The block SHALL drive lamps per state:
- RED: lamp_red=1111.
- GREEN(L): lamp_grn bit L set, other lanes red.
- YELLOW(L): lamp_yel bit L set, other lanes red.
- FAULT: lamp_red as in REQ-022; lamp_yel=lamp_grn=0000.
REQ-015 In RED, the block SHALL increment clr_cnt each cycle, saturating at CLEAR_CYCLES; on a green code for lane L it SHALL enter GREEN(L) only if clr_cnt>=CLEAR_CYCLES, otherwise stay in RED with clearing=1; on any yellow code it SHALL enter FAULT.
REQ-016 In GREEN(L), the block SHALL stay on green L, go to YELLOW(L) on yellow L, and enter FAULT on any other legal code (including 0), since skipping yellow is a violation.
REQ-017 In YELLOW(L), the block SHALL stay on yellow L, and on 0 or any green code go to RED with clr_cnt=0; on yellow of another lane it SHALL enter FAULT.
REQ-018 A green after a yellow, including for the same lane, SHALL always pass through at least CLEAR_CYCLES cycles of all-red.
REQ-019 In any non-FAULT state, an illegal code SHALL hold state, lamps and clr_cnt, and increment ill_cnt; any legal code SHALL clear ill_cnt; ill_cnt reaching FAULT_LIMIT SHALL enter FAULT.
REQ-020 In FAULT, the block SHALL stay in FAULT until fault_clr=1 and code_q=0 in the same cycle, then go to RED with clr_cnt=0 and ill_cnt=0; fault_clr SHALL be ignored in all other states.
REQ-021 The block SHALL assert fault=1 exactly while in FAULT, and clearing=1 only in RED with a pending green code and clr_cnt<CLEAR_CYCLES.
REQ-022 The flash counter SHALL wrap 0..2*FLASH_HALF-1 and restart at 0 on FAULT entry; lamp_red=1111 while counter<FLASH_HALF, else 0000.

Reset
REQ-023 On rst_n=0, asynchronously, the block SHALL set:
- state=RED, code_q=0, clr_cnt=0, ill_cnt=0, flash counter=0.
- lamp_red=1111, lamp_yel=0000, lamp_grn=0000, fault=0, clearing=0.
REQ-024 Reset asserted in any state, including mid-GREEN or mid-FAULT, SHALL immediately force all lamps red with no green or yellow glitch.

Structure
REQ-025 The shared package traffic_light_pkg SHALL hold:
- the light_code localparams;
- lane index constants;
- the driver state encoding.
REQ-026 The flash timing SHALL be a sub-module lamp_flasher (inputs clk, rst_n, enable; output on), instantiated once.

Verification
REQ-027 The bench SHALL cover: reset, then light_code=1 held -> lamps 1111 red for at least 2 cycles with clearing=1, then lamp_grn=0001.
REQ-028 The bench SHALL cover: codes 1 (5 cycles), 2 (3 cycles), then 3 held -> green NS1, yellow NS1, at least 2 all-red cycles, then lamp_grn=0010; fault stays 0.
REQ-029 The bench SHALL cover: code 1 then 3 with no yellow -> fault=1, lamp_red flashes 4 cycles 1111 / 4 cycles 0000.
REQ-030 The bench SHALL cover:
- In GREEN(EW1), code 12 for 2 cycles then 5 -> lamps hold 0100 green, no fault.
- Code 12 for 3 cycles -> fault=1.
REQ-031 The bench SHALL cover: in FAULT, fault_clr=1 with code 5 -> stays in FAULT; fault_clr=1 with code 0 -> fault=0, RED, clr_cnt restarts.
REQ-032 The bench SHALL cover: rst_n pulsed low mid-GREEN(NS2) -> lamp_red=1111 immediately, all counters 0.
